// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the dual-clock FIFO (rd_clk domain).
// Issues fifo_rd_en, captures the word returned one cycle later, and presents
// it on a valid/ready stream through a 2-entry in-order skid buffer.
// Optional macro FIFO_RD_STREAM_BEAT_CNT_EN enables the accepted-beat counter;
// without it beat_cnt is tied to zero.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  flush,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_level,
    output logic [15:0]           beat_cnt
);

    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic                  r_head;
    logic                  r_tail;
    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];

    logic                  w_pop;
    logic [2:0]            w_pending;
    logic                  w_room;

    assign w_pop     = m_valid & m_ready;
    // Words that will occupy the buffer after this edge if nothing new is issued.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room    = (w_pending < 3'd2);

    assign fifo_rd_en = !rd_rst && !flush && !fifo_rd_empty && w_room;

    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_buf[r_head];
    assign buf_level = r_occ;

    // Buffer state: capture returning word at tail, retire head on pop.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (flush) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight) begin
                r_buf[r_tail] <= fifo_rd_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    logic [15:0] r_beat_cnt;

    // Count accepted beats; flush and reset both clear, flush wins over pop.
    always_ff @(posedge rd_clk) begin
        if (rd_rst || flush) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`else
    assign beat_cnt = '0;
`endif

endmodule
